// File: rtl/dtw_accel_axil_ctrl.sv
// dtw_accel_axil_ctrl: AXI4-Lite control/status slave for a multi-core DTW accelerator.
// Holds CTRL (start/abort pulses + mode), CORE_SEL, STATUS, sticky DONE and REF_LEN,
// fans start/abort pulses out to the selected cores and gathers busy/done back.
// Optional feature macro: DTW_IRQ_EN adds the IRQ_EN register (word 5) and the irq output.
module dtw_accel_axil_ctrl #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter int          C_NUM_CORES        = 4,
    parameter logic [31:0] C_REF_LEN_DEFAULT  = 32'd29898
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_NUM_CORES-1:0]            dtw_start,
    output logic [C_NUM_CORES-1:0]            dtw_abort,
    output logic [23:0]                       dtw_mode,
    output logic [31:0]                       dtw_ref_len,
    input  logic [C_NUM_CORES-1:0]            dtw_busy,
    input  logic [C_NUM_CORES-1:0]            dtw_done
`ifdef DTW_IRQ_EN
    ,
    output logic                              irq
`endif
);

    localparam int         PAD        = 32 - C_NUM_CORES;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-channel staging: address and data halves are latched independently
    logic                   aw_latched_q, aw_latched_d;
    logic [2:0]             aw_word_q, aw_word_d;
    logic                   w_latched_q, w_latched_d;
    logic [31:0]            w_data_q, w_data_d;
    logic [3:0]             w_strb_q, w_strb_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;

    // Read channel
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;

    // Register file and core-facing state
    logic [23:0]            mode_q, mode_d;
    logic [C_NUM_CORES-1:0] core_sel_q, core_sel_d;
    logic [C_NUM_CORES-1:0] start_q, start_d;
    logic [C_NUM_CORES-1:0] abort_q, abort_d;
    logic [C_NUM_CORES-1:0] done_q, done_d;
    logic [C_NUM_CORES-1:0] status_q, status_d;
    logic [31:0]            ref_len_q, ref_len_d;
`ifdef DTW_IRQ_EN
    logic [C_NUM_CORES-1:0] irq_en_q, irq_en_d;
    logic                   irq_q, irq_d;
`endif

    logic                   aw_hs, w_hs, ar_hs, commit;
    logic                   wr_mapped;
    logic [C_NUM_CORES-1:0] done_clr;
    logic [31:0]            wmask;
    logic                   unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Expand the latched byte strobes into a per-bit write mask
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{w_strb_q[gi]}};
        end
    endgenerate

    assign aw_hs  = S_AXI_AWVALID && awready_q;
    assign w_hs   = S_AXI_WVALID && wready_q;
    assign ar_hs  = S_AXI_ARVALID && arready_q;
    assign commit = aw_latched_q && w_latched_q;

    // Write word decode: which word indices accept writes with OKAY
    always_comb begin
        wr_mapped = 1'b0;
        case (aw_word_q)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: wr_mapped = 1'b1;
`ifdef DTW_IRQ_EN
            3'd5:                         wr_mapped = 1'b1;
`endif
            default:                      wr_mapped = 1'b0;
        endcase
    end

    // Write path: handshakes, commit into registers, B response, pulse generation
    always_comb begin
        aw_latched_d = aw_latched_q;
        aw_word_d    = aw_word_q;
        w_latched_d  = w_latched_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        mode_d       = mode_q;
        core_sel_d   = core_sel_q;
        ref_len_d    = ref_len_q;
        start_d      = '0;
        abort_d      = '0;
        done_clr     = '0;
`ifdef DTW_IRQ_EN
        irq_en_d     = irq_en_q;
`endif
        if (aw_hs) begin
            aw_latched_d = 1'b1;
            aw_word_d    = S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
            w_latched_d = 1'b1;
            w_data_d    = S_AXI_WDATA;
            w_strb_d    = S_AXI_WSTRB;
        end
        if (commit) begin
            aw_latched_d = 1'b0;
            w_latched_d  = 1'b0;
            bvalid_d     = 1'b1;
            bresp_d      = wr_mapped ? RESP_OKAY : RESP_SLVERR;
            case (aw_word_q)
                3'd0: begin
                    mode_d = (mode_q & ~wmask[31:8]) | (w_data_q[31:8] & wmask[31:8]);
                    // Abort takes priority; a simultaneous start is dropped
                    if (w_strb_q[0] && w_data_q[1]) begin
                        abort_d = core_sel_q;
                    end else if (w_strb_q[0] && w_data_q[0]) begin
                        start_d = core_sel_q;
                    end
                end
                3'd1: core_sel_d = (core_sel_q & ~wmask[C_NUM_CORES-1:0])
                                 | (w_data_q[C_NUM_CORES-1:0] & wmask[C_NUM_CORES-1:0]);
                3'd3: done_clr = w_data_q[C_NUM_CORES-1:0] & wmask[C_NUM_CORES-1:0];
                3'd4: ref_len_d = (ref_len_q & ~wmask) | (w_data_q & wmask);
`ifdef DTW_IRQ_EN
                3'd5: irq_en_d = (irq_en_q & ~wmask[C_NUM_CORES-1:0])
                               | (w_data_q[C_NUM_CORES-1:0] & wmask[C_NUM_CORES-1:0]);
`endif
                default: ;
            endcase
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        // A done pulse arriving with a W1C clear of the same bit keeps the bit set
        done_d    = (done_q & ~done_clr) | dtw_done;
        awready_d = !aw_latched_d && !bvalid_d;
        wready_d  = !w_latched_d && !bvalid_d;
    end

    // Read path: capture data/response at the AR handshake, hold until RREADY
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            case (S_AXI_ARADDR[4:2])
                3'd0: rdata_d = {mode_q, 8'h00};
                3'd1: rdata_d = {{PAD{1'b0}}, core_sel_q};
                3'd2: rdata_d = {{PAD{1'b0}}, status_q};
                3'd3: rdata_d = {{PAD{1'b0}}, done_q};
                3'd4: rdata_d = ref_len_q;
`ifdef DTW_IRQ_EN
                3'd5: rdata_d = {{PAD{1'b0}}, irq_en_q};
`endif
                default: rresp_d = RESP_SLVERR;
            endcase
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
        status_d  = dtw_busy;
`ifdef DTW_IRQ_EN
        irq_d     = |(done_q & irq_en_q);
`endif
    end

    // State registers; reset drops any half-finished transaction
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_latched_q <= 1'b0;
            aw_word_q    <= '0;
            w_latched_q  <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            mode_q       <= '0;
            core_sel_q   <= '0;
            start_q      <= '0;
            abort_q      <= '0;
            done_q       <= '0;
            status_q     <= '0;
            ref_len_q    <= C_REF_LEN_DEFAULT;
`ifdef DTW_IRQ_EN
            irq_en_q     <= '0;
            irq_q        <= 1'b0;
`endif
        end else begin
            aw_latched_q <= aw_latched_d;
            aw_word_q    <= aw_word_d;
            w_latched_q  <= w_latched_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            mode_q       <= mode_d;
            core_sel_q   <= core_sel_d;
            start_q      <= start_d;
            abort_q      <= abort_d;
            done_q       <= done_d;
            status_q     <= status_d;
            ref_len_q    <= ref_len_d;
`ifdef DTW_IRQ_EN
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
`endif
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign dtw_start     = start_q;
    assign dtw_abort     = abort_q;
    assign dtw_mode      = mode_q;
    assign dtw_ref_len   = ref_len_q;
`ifdef DTW_IRQ_EN
    assign irq           = irq_q;
`endif

endmodule

// File: tb/tb_dtw_accel_axil_ctrl.sv
// tb_dtw_accel_axil_ctrl: directed + randomized bench for dtw_accel_axil_ctrl.
// Expected values come from a register-level model of the control block.
module tb_dtw_accel_axil_ctrl;
    localparam int N = 4;
    localparam logic [31:0] REF_DEF = 32'd29898;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    awaddr = '0;
    logic [2:0]    awprot = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [4:0]    araddr = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [N-1:0]  dtw_start, dtw_abort;
    logic [23:0]   dtw_mode;
    logic [31:0]   dtw_ref_len;
    logic [N-1:0]  dtw_busy = '0;
    logic [N-1:0]  dtw_done = '0;
`ifdef DTW_IRQ_EN
    logic          irq;
`endif

    dtw_accel_axil_ctrl #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
        .C_NUM_CORES(N), .C_REF_LEN_DEFAULT(REF_DEF)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .dtw_start(dtw_start), .dtw_abort(dtw_abort), .dtw_mode(dtw_mode), .dtw_ref_len(dtw_ref_len),
        .dtw_busy(dtw_busy), .dtw_done(dtw_done)
`ifdef DTW_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Register-level model
    logic [23:0]  m_mode;
    logic [N-1:0] m_core_sel, m_done, m_irq_en;
    logic [31:0]  m_ref_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode = '0; m_core_sel = '0; m_done = '0; m_irq_en = '0; m_ref_len = REF_DEF;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic word_ok(input logic [2:0] w);
`ifdef DTW_IRQ_EN
        return w <= 3'd5;
`else
        return w <= 3'd4;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] w);
        case (w)
            3'd0: return {m_mode, 8'h00};
            3'd1: return {28'b0, m_core_sel};
            3'd2: return {28'b0, dtw_busy};
            3'd3: return {28'b0, m_done};
            3'd4: return m_ref_len;
`ifdef DTW_IRQ_EN
            3'd5: return {28'b0, m_irq_en};
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Full AXI write with W delayed by w_delay cycles; pulse drives dtw_done in the commit cycle
    task automatic write_check(input string tag, input logic [2:0] word, input logic [31:0] data,
                               input logic [3:0] strb, input int w_delay, input logic [N-1:0] pulse);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0;
        logic [N-1:0] exp_start = '0, exp_abort = '0, clr = '0;
        logic [31:0] full;
        if (word == 3'd0 && strb[0] && data[1]) exp_abort = m_core_sel;
        else if (word == 3'd0 && strb[0] && data[0]) exp_start = m_core_sel;
        case (word)
            3'd0: begin full = merge({m_mode, 8'h00}, data, strb); m_mode = full[31:8]; end
            3'd1: begin full = merge({28'b0, m_core_sel}, data, strb); m_core_sel = full[N-1:0]; end
            3'd3: for (int i = 0; i < N; i++) clr[i] = data[i] & strb[i/8];
            3'd4: m_ref_len = merge(m_ref_len, data, strb);
`ifdef DTW_IRQ_EN
            3'd5: begin full = merge({28'b0, m_irq_en}, data, strb); m_irq_en = full[N-1:0]; end
`endif
            default: ;
        endcase
        m_done = (m_done & ~clr) | pulse;

        awaddr = {word, 2'b00}; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = (w_delay == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1; cyc++;
            if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
            if (hs_w) begin w_done = 1; wvalid = 1'b0; end
            if (!w_done && cyc >= w_delay) wvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, ".handshake"}, {31'b0, aw_done && w_done}, 32'd1);
        dtw_done = pulse;
        bready = 1'b1;
        @(posedge clk); #1;
        dtw_done = '0;
        check({tag, ".bvalid"}, {31'b0, bvalid}, 32'd1);
        check({tag, ".bresp"}, {30'b0, bresp}, word_ok(word) ? 32'd0 : 32'd2);
        check({tag, ".start"}, {28'b0, dtw_start}, {28'b0, exp_start});
        check({tag, ".abort"}, {28'b0, dtw_abort}, {28'b0, exp_abort});
        cyc = 0;
        while (!bvalid && cyc < 10) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        bready = 1'b0;
        check({tag, ".start_off"}, {28'b0, dtw_start}, 32'd0);
        check({tag, ".bvalid_off"}, {31'b0, bvalid}, 32'd0);
        check({tag, ".mode"}, {8'b0, dtw_mode}, {8'b0, m_mode});
        check({tag, ".ref_len"}, dtw_ref_len, m_ref_len);
    endtask

    // AXI read; RREADY is held low for 'hold' cycles while RVALID/RDATA must stay put
    task automatic read_check(input string tag, input logic [2:0] word, input int hold);
        bit hs = 0;
        int cyc = 0;
        logic [31:0] exp_d = model_read(word);
        logic [31:0] exp_r = word_ok(word) ? 32'd0 : 32'd2;
        araddr = {word, 2'b00}; arvalid = 1'b1;
        while (!hs && cyc < 50) begin
            hs = arready;
            @(posedge clk); #1; cyc++;
        end
        arvalid = 1'b0;
        check({tag, ".rvalid"}, {31'b0, rvalid}, 32'd1);
        check({tag, ".rdata"}, rdata, exp_d);
        check({tag, ".rresp"}, {30'b0, rresp}, exp_r);
        for (int i = 0; i < hold; i++) begin
            dtw_busy = dtw_busy + 4'd1;
            @(posedge clk); #1;
            check({tag, ".hold_rvalid"}, {31'b0, rvalid}, 32'd1);
            check({tag, ".hold_rdata"}, rdata, exp_d);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check({tag, ".rvalid_off"}, {31'b0, rvalid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.awready", {31'b0, awready}, 32'd0);
        check("rst.arready", {31'b0, arready}, 32'd0);
        check("rst.bvalid", {31'b0, bvalid}, 32'd0);
        check("rst.rvalid", {31'b0, rvalid}, 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.start", {28'b0, dtw_start}, 32'd0);
        check("rst.mode", {8'b0, dtw_mode}, 32'd0);
        check("rst.ref_len", dtw_ref_len, REF_DEF);
        rst = 1'b0;
        @(posedge clk); #1;
        read_check("t1.ref_len", 3'd4, 0);
        read_check("t1.ctrl", 3'd0, 0);

        // AW ahead of W by 3 cycles; start pulse to selected cores
        write_check("t2.core_sel", 3'd1, 32'h5, 4'hF, 3, '0);
        write_check("t2.start", 3'd0, 32'h1, 4'hF, 3, '0);
        read_check("t2.ctrl", 3'd0, 0);
        write_check("t2.both", 3'd0, 32'hAB03, 4'hF, 1, '0);
        write_check("t2.start_nostrb", 3'd0, 32'h1, 4'hE, 0, '0);

        // Done set vs W1C clear in the same cycle
        write_check("t3.w1c_race", 3'd3, 32'h4, 4'hF, 0, 4'b0100);
        read_check("t3.done_set", 3'd3, 0);
        write_check("t3.w1c", 3'd3, 32'h4, 4'hF, 0, '0);
        read_check("t3.done_clr", 3'd3, 0);

        // Unmapped word and status write
        write_check("t4.unmapped", 3'd7, 32'hDEAD, 4'hF, 0, '0);
        read_check("t4.unmapped", 3'd7, 0);
        write_check("t4.status_wr", 3'd2, 32'hF, 4'hF, 0, '0);
`ifndef DTW_IRQ_EN
        write_check("t4.word5", 3'd5, 32'h3, 4'hF, 0, '0);
        read_check("t4.word5", 3'd5, 0);
`endif

        // Read held with RREADY low while busy changes underneath
        dtw_busy = 4'h9;
        repeat (2) @(posedge clk);
        #1;
        read_check("t5.hold", 3'd2, 5);

`ifdef DTW_IRQ_EN
        // Interrupt follows DONE & IRQ_EN one cycle later
        write_check("t6.irq_en", 3'd5, 32'h2, 4'hF, 0, '0);
        dtw_done = 4'b0010; m_done = m_done | 4'b0010;
        @(posedge clk); #1;
        dtw_done = '0;
        check("t6.irq_lag", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("t6.irq_set", {31'b0, irq}, 32'd1);
        write_check("t6.w1c", 3'd3, 32'h2, 4'hF, 0, '0);
        check("t6.irq_clr", {31'b0, irq}, 32'd0);
        read_check("t6.irq_en_rd", 3'd5, 0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [2:0] w;
            w = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                dtw_busy = 4'($urandom);
                repeat (2) @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 1) == 1)
                write_check($sformatf("rnd%0d.wr%0d", n, w), w, $urandom, 4'($urandom),
                            int'($urandom_range(0, 3)),
                            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            else
                read_check($sformatf("rnd%0d.rd%0d", n, w), w, int'($urandom_range(0, 2)));
        end
        read_check("rnd.final_done", 3'd3, 0);

        // Reset in the middle: AW half latched, read response pending
        awaddr = {3'd4, 2'b00}; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        araddr = {3'd1, 2'b00}; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("t5.pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5.rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("t5.rst_arready", {31'b0, arready}, 32'd0);
        check("t5.rst_awready", {31'b0, awready}, 32'd0);
        check("t5.rst_ref_len", dtw_ref_len, REF_DEF);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wdata = 32'h1234; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        wvalid = 1'b0;
        check("t5.no_stale_b", {31'b0, bvalid}, 32'd0);
        bready = 1'b0;
        // W half is now latched with no address; complete it with a CORE_SEL address
        m_core_sel = 4'h4;
        awaddr = {3'd1, 2'b00}; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(posedge clk); #1;
        check("t5.post_b", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        read_check("t5.post_core_sel", 3'd1, 0);
        read_check("t5.post_ref_len", 3'd4, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
